// File: rtl/mips_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package mips_pkg;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = WORD_W / BYTE_W;
  localparam int unsigned CNT_W      = 16;

  // A frame must carry at least one word and must fit in memory.
  function automatic logic count_ok(input logic [CNT_W-1:0] n, input int unsigned depth);
    return (n != '0) && (32'(n) <= depth);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Collects bytes little-endian into 32-bit words; pulses word_vld_o the cycle
// after the last byte of a word is taken, with word_o holding the word.
module word_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              last_o,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int unsigned BC_W = $clog2(WORD_BYTES);

  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q,  vld_d;

  assign last_o     = (bcnt_q == BC_W'(WORD_BYTES - 1));
  assign word_vld_o = vld_q;
  assign word_o     = word_q;

  always_comb begin
    bcnt_d = bcnt_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr_i) begin
      bcnt_d = '0;
    end else if (byte_vld_i) begin
      // Shift in from the top so the first byte ends up in bits [7:0].
      bcnt_d = bcnt_q + BC_W'(1);
      word_d = {byte_i, word_q[WORD_W-1:BYTE_W]};
      vld_d  = last_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a count-prefixed, XOR-checksummed program over a byte link and
// writes it into instruction memory, holding the core in reset until it is good.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  loader_state_t     state_q, state_d;
  logic [BYTE_W-1:0] cnt_lo_q, cnt_lo_d;
  logic [ADDR_W-1:0] last_q,   last_d;
  logic [ADDR_W-1:0] widx_q,   widx_d;
  logic [ADDR_W-1:0] waddr_q,  waddr_d;
  logic [BYTE_W-1:0] csum_q,   csum_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_n;
  logic             pk_clr, pk_vld, pk_last;

  assign rx_ready = !reset && (state_q inside {CNT_LO, CNT_HI, DATA, CHK});
  assign accept   = rx_valid && rx_ready;
  assign cnt_n    = {rx_data, cnt_lo_q};

  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);
  assign cpu_reset = (state_q != DONE);
  assign waddr     = waddr_q;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (pk_clr),
    .byte_vld_i (pk_vld),
    .byte_i     (rx_data),
    .last_o     (pk_last),
    .word_vld_o (we),
    .word_o     (wdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    last_d   = last_q;
    widx_d   = widx_q;
    waddr_d  = waddr_q;
    csum_d   = csum_q;
    pk_clr   = 1'b0;
    pk_vld   = 1'b0;
    unique case (state_q)
      CNT_LO: if (accept) begin
        cnt_lo_d = rx_data;
        csum_d   = csum_q ^ rx_data;
        state_d  = CNT_HI;
      end
      CNT_HI: if (accept) begin
        csum_d = csum_q ^ rx_data;
        if (count_ok(cnt_n, DEPTH)) begin
          last_d  = ADDR_W'(cnt_n - CNT_W'(1));
          state_d = DATA;
        end else begin
          state_d = ERR;
        end
      end
      DATA: if (accept) begin
        csum_d = csum_q ^ rx_data;
        pk_vld = 1'b1;
        if (pk_last) begin
          // Index stops at the last word so the address never wraps.
          waddr_d = widx_q;
          if (widx_q == last_q) state_d = CHK;
          else                  widx_d  = widx_q + ADDR_W'(1);
        end
      end
      CHK: if (accept) begin
        state_d = (rx_data == csum_q) ? DONE : ERR;
      end
      DONE, ERR: if (start) begin
        state_d  = CNT_LO;
        cnt_lo_d = '0;
        widx_d   = '0;
        csum_d   = '0;
        pk_clr   = 1'b1;
      end
      default: state_d = CNT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CNT_LO;
      cnt_lo_q <= '0;
      last_q   <= '0;
      widx_q   <= '0;
      waddr_q  <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      last_q   <= last_d;
      widx_q   <= widx_d;
      waddr_q  <= waddr_d;
      csum_q   <= csum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader against a parse-the-frame model.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_reset, done, error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .start(start), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed writes {addr, data}
  logic [39:0] wr_q[$];
  always @(negedge clk) if (we === 1'b1) wr_q.push_back({8'(waddr), wdata});

  // Model results
  logic [39:0] exp_wr[$];
  bit          exp_done, exp_err;
  int          exp_acc;
  int          acc_cnt;

  task automatic model(input bq_t b);
    int n;
    logic [7:0] x;
    exp_wr.delete();
    exp_done = 0;
    exp_err  = 0;
    n = int'({b[1], b[0]});
    if (n < 1 || n > DEPTH) begin
      exp_err = 1;
      exp_acc = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < 2 + 4*n; k++) x ^= b[k];
    for (int i = 0; i < n; i++)
      exp_wr.push_back({8'(i), b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]});
    exp_acc = 3 + 4*n;
    if (b[2+4*n] == x) exp_done = 1;
    else               exp_err  = 1;
  endtask

  task automatic make_frame(input int n, input bit bad, input int extra, output bq_t b);
    logic [7:0] x;
    b.delete();
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n; i++) b.push_back(8'($urandom));
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(bad ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
    for (int i = 0; i < extra; i++) b.push_back(8'($urandom));
  endtask

  task automatic send(input bq_t b, input int gmin, input int gmax, input bit rnd_start);
    acc_cnt = 0;
    foreach (b[i]) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b[i];
      start    = rnd_start && rx_ready && ($urandom_range(3, 0) == 0);
      if (rx_ready) acc_cnt++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    logic [39:0] got;
    repeat (3) @(negedge clk);
    chk({tag, ".nwr"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : 40'hx;
      chk({tag, ".wr"}, 64'(got), 64'(exp_wr[i]));
    end
    chk({tag, ".acc"},       64'(acc_cnt), 64'(exp_acc));
    chk({tag, ".done"},      64'(done), 64'(exp_done));
    chk({tag, ".error"},     64'(error), 64'(exp_err));
    chk({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
    chk({tag, ".rx_ready"},  64'(rx_ready), 64'(0));
    wr_q.delete();
  endtask

  task automatic rearm(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".rearm_ready"}, 64'(rx_ready), 64'(1));
    chk({tag, ".rearm_done"},  64'(done), 64'(0));
    chk({tag, ".rearm_err"},   64'(error), 64'(0));
    chk({tag, ".rearm_cpurst"}, 64'(cpu_reset), 64'(1));
  endtask

  initial begin
    bq_t f, g;
    logic [39:0] got;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.rx_ready",  64'(rx_ready), 64'(0));
    chk("rst.we",        64'(we), 64'(0));
    chk("rst.waddr",     64'(waddr), 64'(0));
    chk("rst.wdata",     64'(wdata), 64'(0));
    chk("rst.done",      64'(done), 64'(0));
    chk("rst.error",     64'(error), 64'(0));
    chk("rst.cpu_reset", 64'(cpu_reset), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.rx_ready", 64'(rx_ready), 64'(1));

    // Reference frame
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    model(f);
    chk("ref.model_w0", 64'(exp_wr[0]), 64'({8'h00, 32'h12345678}));
    send(f, 0, 0, 1'b0);
    check_frame("ref");

    // Start in DONE re-arms next cycle
    rearm("start_done");

    // Bad checksum
    f[10] = 8'h29;
    model(f);
    send(f, 0, 0, 1'b0);
    check_frame("badcsum");
    rearm("badcsum");

    // N=0 and N=65 are rejected after the count bytes
    g = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    model(g);
    send(g, 0, 1, 1'b0);
    check_frame("n0");
    rearm("n0");
    g = '{8'h41, 8'h00, 8'h11, 8'h22, 8'h33};
    model(g);
    send(g, 0, 1, 1'b0);
    check_frame("n65");
    rearm("n65");

    // Gapped reference frame plus trailing bytes
    f[10] = 8'h28;
    g = f;
    g.push_back(8'hA5); g.push_back(8'h5A); g.push_back(8'h00);
    model(g);
    send(g, 3, 3, 1'b0);
    check_frame("gapped");
    rearm("gapped");

    // Reset after 5 data bytes
    g = f[0:6];
    send(g, 0, 1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.nwr", 64'(wr_q.size()), 64'(1));
    got = (wr_q.size() > 0) ? wr_q[0] : 40'hx;
    chk("midrst.wr0",       64'(got), 64'({8'h00, 32'h12345678}));
    chk("midrst.cpu_reset", 64'(cpu_reset), 64'(1));
    chk("midrst.rx_ready",  64'(rx_ready), 64'(1));
    chk("midrst.done",      64'(done), 64'(0));
    wr_q.delete();
    model(f);
    send(f, 0, 2, 1'b0);
    check_frame("after_rst");
    rearm("after_rst");

    // N=1 after re-arm
    make_frame(1, 1'b0, 0, g);
    model(g);
    send(g, 0, 1, 1'b1);
    check_frame("n1");
    rearm("n1");

    // Full-depth frame
    make_frame(DEPTH, 1'b0, 1, g);
    model(g);
    send(g, 0, 1, 1'b1);
    check_frame("ndepth");
    rearm("ndepth");

    // Random frames
    for (int t = 0; t < 12; t++) begin
      int n;
      n = int'($urandom_range(8, 1));
      make_frame(n, ($urandom_range(3, 0) == 0), int'($urandom_range(2, 0)), g);
      model(g);
      send(g, 0, 2, 1'b1);
      check_frame($sformatf("rnd%0d", t));
      rearm($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
